bp_stream_beat_tracker: RTL and testbench
=========================================

# bp_stream_beat_tracker

Sequential bookkeeping block for inbound BedRock stream pumps. It holds three independent state elements that a stream FSM uses to walk a multi-beat message:
- a settable up-counter that tracks the beat index;
- a set/clear flag that marks when a message is mid-stream;
- an enable-bypass register that captures the critical address and presents it in the same cycle.

It has no handshake of its own. All control comes from the surrounding pump's combinational logic.

## Interface
Parameters:
- `cnt_max_val_p`, default 7: largest counter value. Counter width is `cnt_width_lp = max(1, clog2(cnt_max_val_p+1))`.
- `cnt_reset_val_p`, default 0: counter value applied on reset. Must be ≤ `cnt_max_val_p`.
- `flag_width_p`, default 1: width of the set/clear flag register. Each bit acts independently.
- `clear_over_set_p`, default 1: 1 means clear wins over set when both are asserted; 0 means set wins.
- `byp_width_p`, default 6: width of the bypass register (the block-offset width).

Ports:
- `clk_i`, in, 1: the single clock.
- `reset_n_i`, in, 1: reset, asynchronous and active-low.
- `cnt_set_i`, in, 1: load `cnt_val_i` into the counter.
- `cnt_en_i`, in, 1: increment the counter.
- `cnt_val_i`, in, `cnt_width_lp`: counter load value.
- `cnt_o`, out, `cnt_width_lp`: current count (registered).
- `flag_set_i`, in, `flag_width_p`: per-bit set.
- `flag_clear_i`, in, `flag_width_p`: per-bit clear.
- `flag_o`, out, `flag_width_p`: flag register value.
- `byp_en_i`, in, 1: capture enable, which also selects bypass.
- `byp_data_i`, in, `byp_width_p`: data to capture.
- `byp_data_o`, out, `byp_width_p`: bypassed or held data.

## Operation
Counter:
- Priority is reset, then set, then enable.
- `set_i` loads `cnt_val_i` regardless of `cnt_en_i`.
- `en_i` alone loads `cnt_o+1`. Incrementing at `cnt_max_val_p` wraps to 0.
- With neither asserted, the count holds.

Flag, per bit b, when `clear_over_set_p`=1:
- next = (q | set) & ~clear.

Flag, per bit b, when `clear_over_set_p`=0:
- next = (q & ~clear) | set.

Flag, common to both modes:
- Set alone gives 1.
- Clear alone gives 0.
- Neither asserted holds the value.
- Set and clear together give 0 or 1, according to `clear_over_set_p`.

Bypass register:
- `byp_data_o = byp_en_i ? byp_data_i : held`, combinationally.
- On the clock edge with `byp_en_i`=1, held ← `byp_data_i`; otherwise held keeps its value.
- Pump usage is `byp_en_i = ~flag_o[0]`. The critical address therefore tracks the header while idle and is frozen while streaming.

Reset values:
- `cnt_o` = `cnt_reset_val_p`.
- `flag_o` = 0.
- Bypass held value = 0. During reset, `byp_data_o` still equals `byp_data_i` when `byp_en_i`=1, else 0.

Parameter checks, enforced by elaboration-time assertions:
- `cnt_reset_val_p` ≤ `cnt_max_val_p`.
- All widths ≥ 1.

## Timing
- All state updates on the rising edge of `clk_i`.
- Counter and flag register have one-cycle latency from input to output.
- The bypass path has zero latency from `byp_data_i` to `byp_data_o` when `byp_en_i`=1. It is a combinational path and is not registered.
- Reset assertion (`reset_n_i` falling) clears all state immediately, without waiting for a clock edge.
- Reset deassertion is sampled at the next rising edge; the first update occurs on the first edge with `reset_n_i`=1.
- Inputs asserted while `reset_n_i`=0 have no effect on state.
- Asserting reset mid-stream abandons the count and flag state. No partial state survives.
- No internal combinational loops. `flag_o` and `cnt_o` depend only on state.

## Test plan
- Reset and load:
  - Drive `reset_n_i`=0 mid-cycle with count 5 and flag 1 → `cnt_o`=0 and `flag_o`=0 asynchronously, before the next edge.
  - Release reset, pulse `cnt_set_i` with `cnt_val_i`=2 → `cnt_o`=2 next cycle.
- Counter wrap and priority:
  - From 6 with `cnt_en_i` held → 7, then 0, then 1.
  - Set with val=3 together with en → 3 (set wins).
- Flag:
  - set → `flag_o`=1, then hold for 3 cycles → stays 1.
  - clear → 0.
  - set and clear together → 0 with `clear_over_set_p`=1; repeat with `clear_over_set_p`=0 → 1.
- Bypass:
  - `byp_en_i`=1 with data 0x2A → `byp_data_o`=0x2A in the same cycle.
  - Deassert en and change data to 0x15 → output stays 0x2A.
  - Re-enable with data 0x07 → output 0x07 immediately, and 0x07 is held afterward.
- Pump sequence, `cnt_max_val_p`=7:
  - Stream-new cycle: set counter to first+1=3, set flag, `byp_en_i`=1 with address 0x10.
  - Next 5 cycles: increment (counts 4, 5, 6, 7, 0); `byp_data_o` stays 0x10.
  - Done cycle: set counter to 0 and clear flag in the same cycle → `cnt_o`=0 and `flag_o`=0 next cycle.
- Width corner, `cnt_max_val_p`=0:
  - `cnt_width_lp`=1; `cnt_o` stays 0 under `cnt_en_i`.
  - `cnt_set_i` with val=0 → 0.

Source files
------------

// File: rtl/bp_stream_beat_tracker.sv
// Beat-index counter, mid-stream flag and critical-address bypass register
// used by inbound BedRock stream pumps to walk a multi-beat message.
module bp_stream_beat_tracker #(
    parameter int cnt_max_val_p    = 7,
    parameter int cnt_reset_val_p  = 0,
    parameter int flag_width_p     = 1,
    parameter int clear_over_set_p = 1,
    parameter int byp_width_p      = 6,
    localparam int cnt_width_lp    = (cnt_max_val_p > 0) ? $clog2(cnt_max_val_p + 1) : 1
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    cnt_set_i,
    input  logic                    cnt_en_i,
    input  logic [cnt_width_lp-1:0] cnt_val_i,
    output logic [cnt_width_lp-1:0] cnt_o,
    input  logic [flag_width_p-1:0] flag_set_i,
    input  logic [flag_width_p-1:0] flag_clear_i,
    output logic [flag_width_p-1:0] flag_o,
    input  logic                    byp_en_i,
    input  logic [byp_width_p-1:0]  byp_data_i,
    output logic [byp_width_p-1:0]  byp_data_o
);

    if (cnt_reset_val_p > cnt_max_val_p) begin : g_bad_reset_val
        $error("cnt_reset_val_p must not exceed cnt_max_val_p");
    end
    if (cnt_max_val_p < 0) begin : g_bad_max_val
        $error("cnt_max_val_p must be non-negative");
    end
    if (flag_width_p < 1 || byp_width_p < 1) begin : g_bad_width
        $error("flag_width_p and byp_width_p must be at least 1");
    end

    logic [cnt_width_lp-1:0] cnt_q;
    logic [cnt_width_lp-1:0] cnt_inc;
    logic [flag_width_p-1:0] flag_q;
    logic [flag_width_p-1:0] flag_next;
    logic [byp_width_p-1:0]  byp_held;

    // Increment wraps back to zero once the last legal beat index is reached.
    always_comb begin
        cnt_inc = cnt_q + cnt_width_lp'(1);
        if (cnt_q == cnt_width_lp'(cnt_max_val_p)) begin
            cnt_inc = '0;
        end
    end

    always_comb begin
        flag_next = flag_q;
        if (clear_over_set_p != 0) begin
            flag_next = (flag_q | flag_set_i) & ~flag_clear_i;
        end else begin
            flag_next = (flag_q & ~flag_clear_i) | flag_set_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q    <= cnt_width_lp'(cnt_reset_val_p);
            flag_q   <= '0;
            byp_held <= '0;
        end else begin
            if (cnt_set_i) begin
                cnt_q <= cnt_val_i;
            end else if (cnt_en_i) begin
                cnt_q <= cnt_inc;
            end
            flag_q <= flag_next;
            if (byp_en_i) begin
                byp_held <= byp_data_i;
            end
        end
    end

    assign cnt_o  = cnt_q;
    assign flag_o = flag_q;
    // Enable doubles as the select so a freshly captured value is visible this cycle.
    assign byp_data_o = byp_en_i ? byp_data_i : byp_held;

endmodule

// File: tb/tb_bp_stream_beat_tracker.sv
// Directed bench for bp_stream_beat_tracker: default, set-over-clear and
// single-value-counter configurations driven from shared stimulus.
module tb_bp_stream_beat_tracker;

    logic       clk_i = 1'b0;
    logic       reset_n_i = 1'b1;
    logic       cnt_set_i = 1'b0;
    logic       cnt_en_i = 1'b0;
    logic [2:0] cnt_val_i = '0;
    logic [0:0] flag_set_i = '0;
    logic [0:0] flag_clear_i = '0;
    logic       byp_en_i = 1'b0;
    logic [5:0] byp_data_i = '0;

    logic [2:0] cnt_o;
    logic [0:0] flag_o;
    logic [5:0] byp_data_o;

    logic [2:0] s_cnt_o;
    logic [0:0] s_flag_o;
    logic [5:0] s_byp_data_o;

    logic       z_cnt_set_i = 1'b0;
    logic       z_cnt_en_i = 1'b0;
    logic [0:0] z_cnt_val_i = '0;
    logic [0:0] z_cnt_o;
    logic [0:0] z_flag_o;
    logic [5:0] z_byp_data_o;

    int total = 0;
    int bad = 0;

    always #5 clk_i = ~clk_i;

    bp_stream_beat_tracker dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .cnt_set_i(cnt_set_i), .cnt_en_i(cnt_en_i), .cnt_val_i(cnt_val_i), .cnt_o(cnt_o),
        .flag_set_i(flag_set_i), .flag_clear_i(flag_clear_i), .flag_o(flag_o),
        .byp_en_i(byp_en_i), .byp_data_i(byp_data_i), .byp_data_o(byp_data_o)
    );

    bp_stream_beat_tracker #(.clear_over_set_p(0)) dut_sw (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .cnt_set_i(cnt_set_i), .cnt_en_i(cnt_en_i), .cnt_val_i(cnt_val_i), .cnt_o(s_cnt_o),
        .flag_set_i(flag_set_i), .flag_clear_i(flag_clear_i), .flag_o(s_flag_o),
        .byp_en_i(byp_en_i), .byp_data_i(byp_data_i), .byp_data_o(s_byp_data_o)
    );

    bp_stream_beat_tracker #(.cnt_max_val_p(0)) dut_z (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .cnt_set_i(z_cnt_set_i), .cnt_en_i(z_cnt_en_i), .cnt_val_i(z_cnt_val_i), .cnt_o(z_cnt_o),
        .flag_set_i(flag_set_i), .flag_clear_i(flag_clear_i), .flag_o(z_flag_o),
        .byp_en_i(byp_en_i), .byp_data_i(byp_data_i), .byp_data_o(z_byp_data_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        cnt_set_i = 1'b0; cnt_en_i = 1'b0; cnt_val_i = '0;
        flag_set_i = '0; flag_clear_i = '0;
    endtask

    task automatic test_reset();
        #1 reset_n_i = 1'b0;
        tick(); tick();
        total++; if (cnt_o !== 3'd0) begin bad++; $display("FAIL reset_cnt: got=%0d exp=0", cnt_o); end
        total++; if (flag_o !== 1'b0) begin bad++; $display("FAIL reset_flag: got=%0d exp=0", flag_o); end
        total++; if (byp_data_o !== 6'h00) begin bad++; $display("FAIL reset_byp_off: got=%h exp=00", byp_data_o); end
        byp_en_i = 1'b1; byp_data_i = 6'h33; #1;
        total++; if (byp_data_o !== 6'h33) begin bad++; $display("FAIL reset_byp_on: got=%h exp=33", byp_data_o); end
        // inputs across an edge in reset must not change state
        cnt_en_i = 1'b1; cnt_set_i = 1'b1; cnt_val_i = 3'd4; flag_set_i = 1'b1;
        tick();
        byp_en_i = 1'b0; #1;
        total++; if (cnt_o !== 3'd0) begin bad++; $display("FAIL reset_cnt_frozen: got=%0d exp=0", cnt_o); end
        total++; if (flag_o !== 1'b0) begin bad++; $display("FAIL reset_flag_frozen: got=%0d exp=0", flag_o); end
        total++; if (byp_data_o !== 6'h00) begin bad++; $display("FAIL reset_byp_frozen: got=%h exp=00", byp_data_o); end
        idle_inputs();
        reset_n_i = 1'b1;
        tick();
        total++; if (cnt_o !== 3'd0) begin bad++; $display("FAIL post_release_cnt: got=%0d exp=0", cnt_o); end
        // build mid-stream state, then pull reset between edges
        cnt_set_i = 1'b1; cnt_val_i = 3'd5; flag_set_i = 1'b1;
        tick();
        idle_inputs();
        total++; if (cnt_o !== 3'd5) begin bad++; $display("FAIL pre_async_cnt: got=%0d exp=5", cnt_o); end
        total++; if (flag_o !== 1'b1) begin bad++; $display("FAIL pre_async_flag: got=%0d exp=1", flag_o); end
        #2 reset_n_i = 1'b0;
        #1;
        total++; if (cnt_o !== 3'd0) begin bad++; $display("FAIL async_cnt: got=%0d exp=0", cnt_o); end
        total++; if (flag_o !== 1'b0) begin bad++; $display("FAIL async_flag: got=%0d exp=0", flag_o); end
        total++; if (s_flag_o !== 1'b0) begin bad++; $display("FAIL async_flag_sw: got=%0d exp=0", s_flag_o); end
        tick();
        reset_n_i = 1'b1;
    endtask

    task automatic test_load();
        cnt_set_i = 1'b1; cnt_val_i = 3'd2;
        tick();
        idle_inputs();
        total++; if (cnt_o !== 3'd2) begin bad++; $display("FAIL load: got=%0d exp=2", cnt_o); end
    endtask

    task automatic test_counter_wrap();
        logic [2:0] exp_seq [4];
        exp_seq[0] = 3'd7; exp_seq[1] = 3'd0; exp_seq[2] = 3'd1; exp_seq[3] = 3'd1;
        cnt_set_i = 1'b1; cnt_val_i = 3'd6;
        tick();
        idle_inputs();
        total++; if (cnt_o !== 3'd6) begin bad++; $display("FAIL wrap_start: got=%0d exp=6", cnt_o); end
        for (int i = 0; i < 4; i++) begin
            cnt_en_i = (i < 3);
            tick();
            total++;
            if (cnt_o !== exp_seq[i]) begin bad++; $display("FAIL wrap_step%0d: got=%0d exp=%0d", i, cnt_o, exp_seq[i]); end
        end
        idle_inputs();
    endtask

    task automatic test_set_priority();
        cnt_set_i = 1'b1; cnt_en_i = 1'b1; cnt_val_i = 3'd3;
        tick();
        idle_inputs();
        total++; if (cnt_o !== 3'd3) begin bad++; $display("FAIL set_over_en: got=%0d exp=3", cnt_o); end
    endtask

    task automatic test_flag();
        flag_set_i = 1'b1;
        tick();
        idle_inputs();
        total++; if (flag_o !== 1'b1) begin bad++; $display("FAIL flag_set: got=%0d exp=1", flag_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (flag_o !== 1'b1) begin bad++; $display("FAIL flag_hold%0d: got=%0d exp=1", i, flag_o); end
        end
        flag_clear_i = 1'b1;
        tick();
        idle_inputs();
        total++; if (flag_o !== 1'b0) begin bad++; $display("FAIL flag_clear: got=%0d exp=0", flag_o); end
        // both asserted from 0
        flag_set_i = 1'b1; flag_clear_i = 1'b1;
        tick();
        idle_inputs();
        total++; if (flag_o !== 1'b0) begin bad++; $display("FAIL flag_both_from0_cos1: got=%0d exp=0", flag_o); end
        total++; if (s_flag_o !== 1'b1) begin bad++; $display("FAIL flag_both_from0_cos0: got=%0d exp=1", s_flag_o); end
        // both asserted from 1
        flag_set_i = 1'b1;
        tick();
        flag_clear_i = 1'b1;
        tick();
        idle_inputs();
        total++; if (flag_o !== 1'b0) begin bad++; $display("FAIL flag_both_from1_cos1: got=%0d exp=0", flag_o); end
        total++; if (s_flag_o !== 1'b1) begin bad++; $display("FAIL flag_both_from1_cos0: got=%0d exp=1", s_flag_o); end
        flag_clear_i = 1'b1;
        tick();
        idle_inputs();
        total++; if (s_flag_o !== 1'b0) begin bad++; $display("FAIL flag_clear_cos0: got=%0d exp=0", s_flag_o); end
    endtask

    task automatic test_bypass();
        byp_en_i = 1'b1; byp_data_i = 6'h2A; #1;
        total++; if (byp_data_o !== 6'h2A) begin bad++; $display("FAIL byp_pass: got=%h exp=2a", byp_data_o); end
        tick();
        byp_en_i = 1'b0; byp_data_i = 6'h15; #1;
        total++; if (byp_data_o !== 6'h2A) begin bad++; $display("FAIL byp_hold: got=%h exp=2a", byp_data_o); end
        tick();
        total++; if (byp_data_o !== 6'h2A) begin bad++; $display("FAIL byp_hold_edge: got=%h exp=2a", byp_data_o); end
        byp_en_i = 1'b1; byp_data_i = 6'h07; #1;
        total++; if (byp_data_o !== 6'h07) begin bad++; $display("FAIL byp_reenable: got=%h exp=07", byp_data_o); end
        tick();
        byp_en_i = 1'b0; byp_data_i = 6'h3F; #1;
        total++; if (byp_data_o !== 6'h07) begin bad++; $display("FAIL byp_recapture: got=%h exp=07", byp_data_o); end
    endtask

    task automatic test_pump_sequence();
        logic [2:0] exp_cnt [5];
        exp_cnt[0] = 3'd4; exp_cnt[1] = 3'd5; exp_cnt[2] = 3'd6; exp_cnt[3] = 3'd7; exp_cnt[4] = 3'd0;
        cnt_set_i = 1'b1; cnt_val_i = 3'd3; flag_set_i = 1'b1;
        byp_en_i = 1'b1; byp_data_i = 6'h10; #1;
        total++; if (byp_data_o !== 6'h10) begin bad++; $display("FAIL pump_hdr_byp: got=%h exp=10", byp_data_o); end
        tick();
        idle_inputs();
        byp_en_i = 1'b0; byp_data_i = 6'h22;
        total++; if (cnt_o !== 3'd3) begin bad++; $display("FAIL pump_first_cnt: got=%0d exp=3", cnt_o); end
        total++; if (flag_o !== 1'b1) begin bad++; $display("FAIL pump_first_flag: got=%0d exp=1", flag_o); end
        for (int i = 0; i < 5; i++) begin
            cnt_en_i = 1'b1;
            byp_data_i = 6'(6'h20 + i);
            tick();
            total++;
            if (cnt_o !== exp_cnt[i]) begin bad++; $display("FAIL pump_beat%0d_cnt: got=%0d exp=%0d", i, cnt_o, exp_cnt[i]); end
            total++;
            if (byp_data_o !== 6'h10) begin bad++; $display("FAIL pump_beat%0d_byp: got=%h exp=10", i, byp_data_o); end
        end
        cnt_en_i = 1'b0; cnt_set_i = 1'b1; cnt_val_i = 3'd0; flag_clear_i = 1'b1;
        tick();
        idle_inputs();
        byp_en_i = 1'b1;
        total++; if (cnt_o !== 3'd0) begin bad++; $display("FAIL pump_done_cnt: got=%0d exp=0", cnt_o); end
        total++; if (flag_o !== 1'b0) begin bad++; $display("FAIL pump_done_flag: got=%0d exp=0", flag_o); end
        byp_en_i = 1'b0;
    endtask

    task automatic test_width_corner();
        total++; if (z_cnt_o !== 1'b0) begin bad++; $display("FAIL z_start: got=%0d exp=0", z_cnt_o); end
        z_cnt_en_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (z_cnt_o !== 1'b0) begin bad++; $display("FAIL z_en%0d: got=%0d exp=0", i, z_cnt_o); end
        end
        z_cnt_en_i = 1'b0; z_cnt_set_i = 1'b1; z_cnt_val_i = 1'b0;
        tick();
        z_cnt_set_i = 1'b0;
        total++; if (z_cnt_o !== 1'b0) begin bad++; $display("FAIL z_set0: got=%0d exp=0", z_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_counter_wrap();
        test_set_priority();
        test_flag();
        test_bypass();
        test_pump_sequence();
        test_width_corner();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
